// File: rtl/enc8to3_rr_pkg.sv
// Shared definitions for the round-robin path-request encoder: state encoding,
// default select-code width and the path-count derivation shared with the decoder.
package enc8to3_rr_pkg;

  localparam int unsigned LIMIT_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int unsigned paths_of(input int unsigned limit);
    return 32'd1 << limit;
  endfunction

endpackage

// File: rtl/enc8to3_rr_sel_rr_pick.sv
// Combinational round-robin picker: first set bit of cand at or after ptr, wrapping.
module sel_rr_pick
  import enc8to3_rr_pkg::*;
#(
  parameter  int unsigned LIMIT = LIMIT_DEF,
  localparam int unsigned PATHS = paths_of(LIMIT)
) (
  input  logic [PATHS-1:0] cand,
  input  logic [LIMIT-1:0] ptr,
  output logic [LIMIT-1:0] pick,
  output logic             any_hit
);

  logic [2*PATHS-1:0] dbl;
  logic [PATHS-1:0]   rot;
  logic [LIMIT-1:0]   idx;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then un-rotate by adding ptr.
  always_comb begin
    dbl = {cand, cand};
    rot = dbl[ptr +: PATHS];
    idx = '0;
    for (int unsigned i = 0; i < PATHS; i++) begin
      if (rot[PATHS-1-i]) idx = LIMIT'(PATHS-1-i);
    end
    pick    = idx + ptr;
    any_hit = |cand;
  end

endmodule

// File: rtl/enc8to3_rr.sv
// Collects sticky one-hot path requests and hands them out round-robin as
// select codes over a valid/ready handshake.
module enc8to3_rr
  import enc8to3_rr_pkg::*;
#(
  parameter  int unsigned LIMIT = LIMIT_DEF,
  localparam int unsigned PATHS = paths_of(LIMIT)
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic [PATHS-1:0] path_req,
  input  logic             sel_ready,
  output logic [LIMIT-1:0] sel_out,
  output logic             sel_valid,
  output logic [LIMIT:0]   pend_cnt
);

  state_e           state_q;
  logic [PATHS-1:0] pend_q, pend_d;
  logic [LIMIT-1:0] ptr_q;
  logic [LIMIT-1:0] sel_out_q;
  logic             sel_valid_q;
  logic [LIMIT:0]   pend_cnt_q, pend_cnt_d;

  logic [PATHS-1:0] cand;
  logic [PATHS-1:0] pick_oh;
  logic [LIMIT-1:0] pick;
  logic             any_hit;
  logic             load;
  logic             grant;

  sel_rr_pick #(.LIMIT(LIMIT)) u_pick (
    .cand    (cand),
    .ptr     (ptr_q),
    .pick    (pick),
    .any_hit (any_hit)
  );

  // Pending absorbs every new request each cycle; only a fresh grant clears its own bit,
  // so a re-request of the index in flight is kept and served again later.
  always_comb begin
    cand       = pend_q | path_req;
    load       = (state_q == ST_IDLE) || sel_ready;
    grant      = load && any_hit;
    pick_oh    = {{(PATHS-1){1'b0}}, 1'b1} << pick;
    pend_d     = grant ? (cand & ~pick_oh) : cand;
    pend_cnt_d = '0;
    for (int unsigned i = 0; i < PATHS; i++) begin
      pend_cnt_d = pend_cnt_d + (LIMIT+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      ptr_q       <= '0;
      sel_out_q   <= '0;
      sel_valid_q <= 1'b0;
      pend_cnt_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            sel_out_q   <= pick;
            sel_valid_q <= 1'b1;
            ptr_q       <= pick + LIMIT'(1);
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (grant) begin
            sel_out_q   <= pick;
            sel_valid_q <= 1'b1;
            ptr_q       <= pick + LIMIT'(1);
          end else if (sel_ready) begin
            sel_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_out   = sel_out_q;
  assign sel_valid = sel_valid_q;
  assign pend_cnt  = pend_cnt_q;

endmodule

// File: tb/tb_enc8to3_rr.sv
// Scoreboard bench: stimulus queues expected grant codes, a negedge monitor checks each handshake.
module tb_enc8to3_rr;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] path_req = '0;
  logic       sel_ready = 1'b0;
  logic [2:0] sel_out;
  logic       sel_valid;
  logic [3:0] pend_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  bit done = 1'b0;

  enc8to3_rr #(.LIMIT(3)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .path_req  (path_req),
    .sel_ready (sel_ready),
    .sel_out   (sel_out),
    .sel_valid (sel_valid),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: a handshake completes at the next rising edge when valid and ready are both high.
  always @(negedge clk1) begin
    if (!done && !rst && sel_valid && sel_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_grant: got sel_out=%0d expected none at %0t", sel_out, $time);
      end else begin
        chk("grant_sel_out", int'(sel_out), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with all requests high; they must be discarded.
    rst = 1'b1; path_req = 8'hFF; sel_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", int'(sel_valid), 0);
    chk("rst_pend", int'(pend_cnt), 0);
    chk("rst_sel", int'(sel_out), 0);
    rst = 1'b0; path_req = 8'h00;
    tick();
    chk("post_rst_valid", int'(sel_valid), 0);
    chk("post_rst_pend", int'(pend_cnt), 0);

    // Single request, one-cycle latency.
    sel_ready = 1'b1; path_req = 8'h20;
    exp_q.push_back(5);
    tick();
    path_req = 8'h00;
    chk("single_valid", int'(sel_valid), 1);
    chk("single_pend", int'(pend_cnt), 0);
    tick();
    chk("single_idle", int'(sel_valid), 0);

    // Round robin from ptr=0, twice to exercise the 7->0 wrap.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      path_req = 8'h81;
      exp_q.push_back(0);
      exp_q.push_back(7);
      tick();
      path_req = 8'h00;
      chk("rr_first_pend", int'(pend_cnt), 1);
      tick();
      chk("rr_second_valid", int'(sel_valid), 1);
      chk("rr_second_pend", int'(pend_cnt), 0);
      tick();
      chk("rr_done", int'(sel_valid), 0);
    end

    // Backpressure: grant 1 held for 4 cycles, then 2, 3.
    sel_ready = 1'b0; path_req = 8'h0E;
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    tick();
    path_req = 8'h00;
    for (int c = 0; c < 4; c++) begin
      chk("bp_hold_sel", int'(sel_out), 1);
      chk("bp_hold_valid", int'(sel_valid), 1);
      chk("bp_pend", int'(pend_cnt), 2);
      tick();
    end
    sel_ready = 1'b1;
    tick();
    chk("bp_pend_after1", int'(pend_cnt), 1);
    tick();
    chk("bp_pend_after2", int'(pend_cnt), 0);
    tick();
    chk("bp_done", int'(sel_valid), 0);

    // Re-request of the index in flight is latched and served again.
    sel_ready = 1'b0; path_req = 8'h10;
    exp_q.push_back(4);
    exp_q.push_back(4);
    tick();
    chk("rereq_sel", int'(sel_out), 4);
    chk("rereq_pend0", int'(pend_cnt), 0);
    tick();
    path_req = 8'h00;
    chk("rereq_pend1", int'(pend_cnt), 1);
    sel_ready = 1'b1;
    tick();
    chk("rereq_again_valid", int'(sel_valid), 1);
    chk("rereq_again_pend", int'(pend_cnt), 0);
    tick();
    chk("rereq_done", int'(sel_valid), 0);

    // Mid-operation reset: grant 5 in flight, pending F0; grant dropped without handshake.
    sel_ready = 1'b0; path_req = 8'hF0;
    tick();
    tick();
    path_req = 8'h00;
    chk("mid_pend", int'(pend_cnt), 4);
    chk("mid_sel", int'(sel_out), 5);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", int'(sel_valid), 0);
    chk("mid_rst_sel", int'(sel_out), 0);
    chk("mid_rst_pend", int'(pend_cnt), 0);
    rst = 1'b0; sel_ready = 1'b1; path_req = 8'h01;
    exp_q.push_back(0);
    tick();
    path_req = 8'h00;
    chk("post_mid_valid", int'(sel_valid), 1);
    tick();
    chk("post_mid_idle", int'(sel_valid), 0);

    done = 1'b1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
